// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back
// sequencing with memory wait states and a retired-instruction counter.
module multicycle_control_unit #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ins,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_r, is_mem, is_beq, is_addi, is_j;
  logic retire;
  logic [3:0] out_s;

  assign is_r    = (ins == OP_R);
  assign is_mem  = (ins == OP_LW) || (ins == OP_SW);
  assign is_beq  = (ins == OP_BEQ);
  assign is_addi = (ins == OP_ADDI) && ENABLE_ADDI;
  assign is_j    = (ins == OP_J) && ENABLE_JUMP;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC;
          is_mem:  state_d = S_MEMADR;
          is_beq:  state_d = S_BRANCH;
          is_addi: state_d = S_ADDIEX;
          is_j:    state_d = S_JUMP;
          default: state_d = S_TRAP;
        endcase
      end
      // op_q was captured in DECODE; only lw/sw reach MEMADR
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  assign op_d = (state_q == S_DECODE) ? ins : op_q;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_ADDIWB,
      S_JUMP:  retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_ONE : retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // While reset is held the datapath sees FETCH strobes
  assign out_s = rst_n ? state_q : S_FETCH;

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    ALUOp      = 2'b00;
    illegal    = 1'b0;
    case (out_s)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: four configurations driven in
// lockstep, checked against a per-instruction path model.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal;
  } strb_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] ins;
    logic       mr;
    bit         chk;
    int         st;
    int         ret;
  } vec_t;

  // instance g: bit g of each mask
  localparam logic [3:0] PH = 4'b1001;
  localparam logic [3:0] PA = 4'b1011;
  localparam logic [3:0] PJ = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mr = 1'b1;
  logic [5:0] ins = 6'd0;

  always #5 clk = ~clk;

  strb_t       so [4];
  logic [3:0]  st [4];
  logic [15:0] rt [4];

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W = (g == 3) ? 4 : 16;
    logic pw, br, io, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, ps, aop;
    logic [3:0] s;
    logic [W-1:0] r;
    multicycle_control_unit #(
      .ENABLE_ADDI(PA[g]),
      .ENABLE_JUMP(PJ[g]),
      .TRAP_HALT(PH[g]),
      .CNT_W(W)
    ) u (
      .clk(clk), .rst_n(rst_n), .ins(ins), .mem_ready(mr),
      .pc_write(pw), .branch(br), .iord(io), .mem_read(mrd),
      .mem_write(mwr), .ir_write(irw), .mem_to_reg(m2r),
      .reg_dst(rd), .reg_write(rw), .alu_src_a(asa),
      .alu_src_b(asb), .pc_src(ps), .ALUOp(aop),
      .state(s), .illegal(ill), .retired(r)
    );
    assign so[g] = {pw, br, io, mrd, mwr, irw, m2r, rd, rw,
                    asa, asb, ps, aop, ill};
    assign st[g] = s;
    assign rt[g] = 16'(r);
  end

  int n_tests = 0;
  int n_fail = 0;

  // Model: each instruction is a fixed list of states after DECODE
  int m_cur [4];
  int m_ret [4];
  int m_len [4];
  int m_idx [4];
  int m_path [4][3];

  function automatic int cw(int g);
    return (g == 3) ? 4 : 16;
  endfunction

  function automatic void plan(int g, logic [5:0] op);
    m_len[g] = 1;
    m_path[g][0] = 12;
    case (op)
      6'b000000: begin m_len[g] = 2; m_path[g][0] = 6; m_path[g][1] = 7; end
      6'b100011: begin
        m_len[g] = 3; m_path[g][0] = 2; m_path[g][1] = 3; m_path[g][2] = 4;
      end
      6'b101011: begin m_len[g] = 2; m_path[g][0] = 2; m_path[g][1] = 5; end
      6'b000100: m_path[g][0] = 8;
      6'b001000: if (PA[g]) begin
        m_len[g] = 2; m_path[g][0] = 9; m_path[g][1] = 10;
      end
      6'b000010: if (PJ[g]) m_path[g][0] = 11;
      default: ;
    endcase
  endfunction

  function automatic void model_edge(logic r, logic [5:0] op, logic m);
    for (int g = 0; g < 4; g++) begin
      if (!r) begin
        m_cur[g] = 0; m_ret[g] = 0; m_len[g] = 0; m_idx[g] = 0;
      end else if (m_cur[g] == 0) begin
        if (m) m_cur[g] = 1;
      end else if (m_cur[g] == 1) begin
        plan(g, op);
        m_cur[g] = m_path[g][0];
        m_idx[g] = 1;
      end else if (m_cur[g] == 12) begin
        m_cur[g] = PH[g] ? 12 : 0;
      end else if ((m_cur[g] == 3 || m_cur[g] == 5) && !m) begin
        m_cur[g] = m_cur[g];
      end else if (m_idx[g] < m_len[g]) begin
        m_cur[g] = m_path[g][m_idx[g]];
        m_idx[g]++;
      end else begin
        m_ret[g] = (m_ret[g] + 1) % (1 << cw(g));
        m_cur[g] = 0;
      end
    end
  endfunction

  function automatic strb_t exp_so(int s_in, logic m, logic r);
    strb_t e;
    int s;
    e = '0;
    s = r ? s_in : 0;
    case (s)
      0: begin
        e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = m; e.pc_write = m;
      end
      1: e.alu_src_b = 2'b11;
      2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3: begin e.iord = 1; e.mem_read = 1; end
      4: begin e.reg_write = 1; e.mem_to_reg = 1; end
      5: begin e.iord = 1; e.mem_write = 1; end
      6: begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7: begin e.reg_write = 1; e.reg_dst = 1; end
      8: begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1;
      end
      9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      10: e.reg_write = 1;
      11: begin e.pc_src = 2'b10; e.pc_write = 1; end
      12: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk_eq(input string nm, input logic [31:0] a,
                        input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      chk_eq($sformatf("state%0d", g), 32'(st[g]), m_cur[g]);
      chk_eq($sformatf("strobes%0d", g), 32'(so[g]),
             32'(exp_so(m_cur[g], mr, rst_n)));
      chk_eq($sformatf("retired%0d", g), 32'(rt[g]), m_ret[g]);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] op,
                     input logic m, input bit chk);
    rst_n = r; ins = op; mr = m;
    #1;
    if (chk) check_all();
    @(posedge clk);
    model_edge(r, op, m);
    @(negedge clk);
  endtask

  vec_t tv[$];

  function automatic void addv(logic r, logic [5:0] op, logic m,
                               bit c, int s, int rr);
    vec_t v;
    v.rst_n = r; v.ins = op; v.mr = m; v.chk = c; v.st = s; v.ret = rr;
    tv.push_back(v);
  endfunction

  int ill0, ill1;
  logic [5:0] rop;

  initial begin
    // reset, R-type
    addv(0, 6'o00, 1, 0, 0, 0);
    addv(0, 6'o00, 1, 1, 0, 0);
    addv(1, 6'o00, 1, 1, 0, 0);
    addv(1, 6'b000000, 1, 1, 1, 0);
    addv(1, 6'o00, 1, 1, 6, 0);
    addv(1, 6'o00, 1, 1, 7, 0);
    // lw with 2 FETCH and 3 MEMRD wait cycles
    addv(1, 6'o00, 0, 1, 0, 1);
    addv(1, 6'o00, 0, 1, 0, 1);
    addv(1, 6'o00, 1, 1, 0, 1);
    addv(1, 6'b100011, 1, 1, 1, 1);
    addv(1, 6'o00, 1, 1, 2, 1);
    addv(1, 6'o00, 0, 1, 3, 1);
    addv(1, 6'o00, 0, 1, 3, 1);
    addv(1, 6'o00, 0, 1, 3, 1);
    addv(1, 6'o00, 1, 1, 3, 1);
    addv(1, 6'o00, 1, 1, 4, 1);
    // sw, beq, j
    addv(1, 6'o00, 1, 1, 0, 2);
    addv(1, 6'b101011, 1, 1, 1, 2);
    addv(1, 6'o00, 1, 1, 2, 2);
    addv(1, 6'o00, 1, 1, 5, 2);
    addv(1, 6'o00, 1, 1, 0, 3);
    addv(1, 6'b000100, 1, 1, 1, 3);
    addv(1, 6'o00, 1, 1, 8, 3);
    addv(1, 6'o00, 1, 1, 0, 4);
    addv(1, 6'b000010, 1, 1, 1, 4);
    addv(1, 6'o00, 1, 1, 11, 4);
    addv(1, 6'o00, 1, 1, 0, 5);

    for (int k = 0; k < tv.size(); k++) begin
      rst_n = tv[k].rst_n; ins = tv[k].ins; mr = tv[k].mr;
      #1;
      if (tv[k].chk) begin
        check_all();
        chk_eq($sformatf("tbl_state[%0d]", k), 32'(st[0]), tv[k].st);
        chk_eq($sformatf("tbl_ret[%0d]", k), 32'(rt[0]), tv[k].ret);
      end
      @(posedge clk);
      model_edge(tv[k].rst_n, tv[k].ins, tv[k].mr);
      @(negedge clk);
    end

    // illegal opcode: halt vs one-cycle trap
    cyc(0, 6'd0, 1, 1);
    cyc(1, 6'd0, 1, 1);
    cyc(1, 6'h3f, 1, 1);
    ill0 = 0; ill1 = 0;
    for (int i = 0; i < 12; i++) begin
      ill0 += int'(so[0].illegal);
      ill1 += int'(so[1].illegal);
      if (i == 1) begin
        chk_eq("nohalt_back_to_fetch", 32'(st[1]), 0);
        chk_eq("nohalt_retired", 32'(rt[1]), 0);
      end
      cyc(1, 6'd0, 1, 1);
    end
    chk_eq("halt_illegal_cycles", ill0, 12);
    chk_eq("nohalt_illegal_cycles", ill1, 1);
    chk_eq("halt_retired", 32'(rt[0]), 0);

    // addi and j disabled on instance 2
    cyc(0, 6'd0, 1, 1);
    cyc(1, 6'd0, 1, 1);
    cyc(1, 6'b001000, 1, 1);
    chk_eq("addi_off_trap", 32'(st[2]), 12);
    chk_eq("addi_on_exec", 32'(st[0]), 9);
    cyc(0, 6'd0, 1, 1);
    cyc(1, 6'd0, 1, 1);
    cyc(1, 6'b000010, 1, 1);
    chk_eq("j_off_trap", 32'(st[2]), 12);
    chk_eq("j_on_jump", 32'(st[0]), 11);

    // 17 R-type: 4-bit counter wraps to 1
    cyc(0, 6'd0, 1, 1);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 6'd0, 1, 1);
      cyc(1, 6'd0, 1, 1);
      cyc(1, 6'd0, 1, 1);
      cyc(1, 6'd0, 1, 1);
    end
    chk_eq("wrap_w4", 32'(rt[3]), 1);
    chk_eq("wrap_w16", 32'(rt[0]), 17);

    // reset during a MEMRD wait
    cyc(0, 6'd0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 6'd0, 1, 1);
    cyc(1, 6'd0, 1, 1);
    cyc(1, 6'b100011, 1, 1);
    cyc(1, 6'd0, 1, 1);
    cyc(1, 6'd0, 0, 1);
    chk_eq("midrst_in_memrd", 32'(st[0]), 3);
    chk_eq("midrst_ret_before", 32'(rt[0]), 1);
    cyc(0, 6'd0, 0, 1);
    chk_eq("midrst_state", 32'(st[0]), 0);
    chk_eq("midrst_retired", 32'(rt[0]), 0);
    chk_eq("midrst_mem_read", 32'(so[0].mem_read), 1);
    chk_eq("midrst_iord", 32'(so[0].iord), 0);

    // random traffic
    cyc(0, 6'd0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000100;
        3: rop = 6'b001000;
        4: rop = 6'b000010;
        5: rop = 6'($urandom);
        default: rop = 6'b000000;
      endcase
      cyc(($urandom % 40) != 0, rop, ($urandom % 4) != 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
